// File: rtl/sram_pkg.sv
// Shared types and analog thresholds for the SRAM read sequencer.
// Holds the column classification enum, the read FSM state enum and the pad voltage windows.
// Optional retry behaviour in the top is enabled by defining SRAM_RD_RETRY_EN.
package sram_pkg;

    // Result of classifying one bitline pair
    typedef enum logic [1:0] {
        DATA_TRUE  = 2'd0,
        DATA_FALSE = 2'd1,
        INDET      = 2'd2
    } state_data_t;

    // Read sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_WL_ON     = 3'd2,
        ST_SENSE     = 3'd3,
        ST_DONE      = 3'd4
    } rd_state_t;

    // Pad voltage windows, bounds inclusive
    localparam real TRUE_MIN  = 1.3;
    localparam real TRUE_MAX  = 2.2;
    localparam real FALSE_MIN = -0.5;
    localparam real FALSE_MAX = 0.7;

endpackage

// File: rtl/sram_sense_cmp.sv
// Per-column sense classifier: maps a real bl/blb pair onto TRUE / FALSE / INDET.
// Latency: combinational.
// Backpressure: none; pure function of the current bitline voltages.
module sram_sense_cmp
    import sram_pkg::*;
(
    input  real         bl,
    input  real         blb,
    output state_data_t data_state
);

    logic bl_true;
    logic bl_false;
    logic blb_true;
    logic blb_false;

    // Window tests, then require the pair to be complementary
    always_comb begin
        bl_true    = (bl  >= TRUE_MIN)  && (bl  <= TRUE_MAX);
        bl_false   = (bl  >= FALSE_MIN) && (bl  <= FALSE_MAX);
        blb_true   = (blb >= TRUE_MIN)  && (blb <= TRUE_MAX);
        blb_false  = (blb >= FALSE_MIN) && (blb <= FALSE_MAX);
        data_state = INDET;
        if (bl_true && blb_false) begin
            data_state = DATA_TRUE;
        end else if (bl_false && blb_true) begin
            data_state = DATA_FALSE;
        end
    end

endmodule

// File: rtl/sram_read_seq.sv
// SRAM row read sequencer: precharge, wordline on, settle, sense, one-cycle valid strobe.
// Latency: rd_valid PRE_CYC+SETTLE_CYC+2 cycles after accept (more if a retry occurs).
// Backpressure: rd_ready only in IDLE; requests in other states are dropped. Macro SRAM_RD_RETRY_EN adds one re-read on sense error.
module sram_read_seq
    import sram_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int ADDR_W     = 3,
    parameter int COLS       = 8,
    parameter int PRE_CYC    = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [ROWS-1:0]   row_rd,
    output logic              pre_en,
    input  real               bl_rd  [COLS],
    input  real               blb_rd [COLS],
    output logic [COLS-1:0]   rd_data,
    output logic [COLS-1:0]   rd_err,
`ifdef SRAM_RD_RETRY_EN
    output logic              rd_retried,
`endif
    output logic              rd_valid
);

    localparam int CNT_MAX = (PRE_CYC > SETTLE_CYC) ? PRE_CYC : SETTLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    rd_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COLS-1:0]   data_q, data_d;
    logic [COLS-1:0]   err_q, err_d;
    logic              addr_ok;
`ifdef SRAM_RD_RETRY_EN
    logic              retry_q, retry_d;
`endif

    state_data_t       col_state [COLS];
    logic [COLS-1:0]   sense_data;
    logic [COLS-1:0]   sense_err;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        sram_sense_cmp u_cmp (
            .bl         (bl_rd[c]),
            .blb        (blb_rd[c]),
            .data_state (col_state[c])
        );
    end

    // Out-of-range rows drive no wordline, so every column reads as indeterminate
    assign addr_ok = (int'(addr_q) < ROWS);

    // Collapse per-column classification into data/err words
    always_comb begin
        sense_data = '0;
        sense_err  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!addr_ok || (col_state[c] == INDET)) begin
                sense_err[c] = 1'b1;
            end else if (col_state[c] == DATA_TRUE) begin
                sense_data[c] = 1'b1;
            end
        end
    end

    // State register; reset drops the wordline immediately via state_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= '0;
`ifdef SRAM_RD_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef SRAM_RD_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef SRAM_RD_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_addr;
                    cnt_d   = CNT_W'(PRE_CYC - 1);
                    state_d = ST_PRECHARGE;
`ifdef SRAM_RD_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            ST_PRECHARGE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = ST_WL_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WL_ON: begin
                if (cnt_q == '0) begin
                    state_d = ST_SENSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SENSE: begin
                data_d  = sense_data;
                err_d   = sense_err;
                state_d = ST_DONE;
`ifdef SRAM_RD_RETRY_EN
                // First failed sense gets one full re-read; the second result stands
                if ((sense_err != '0) && !retry_q) begin
                    retry_d = 1'b1;
                    cnt_d   = CNT_W'(PRE_CYC - 1);
                    state_d = ST_PRECHARGE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; precharge and wordline are mutually exclusive by state
    always_comb begin
        rd_ready = (state_q == ST_IDLE);
        pre_en   = (state_q == ST_PRECHARGE);
        rd_valid = (state_q == ST_DONE);
        row_rd   = '0;
        if (((state_q == ST_WL_ON) || (state_q == ST_SENSE)) && addr_ok) begin
            row_rd = ROWS'(1) << addr_q;
        end
        rd_data  = data_q;
        rd_err   = err_q;
`ifdef SRAM_RD_RETRY_EN
        rd_retried = retry_q && (state_q == ST_DONE);
`endif
    end

endmodule

// File: tb/tb_sram_read_seq.sv
// Directed bench for sram_read_seq: timing, classification windows, back-to-back requests, reset abort.
// ADDR_W widened to 4 so that an out-of-range row (9) can be presented with ROWS=8.
// Works with and without SRAM_RD_RETRY_EN defined.
module tb_sram_read_seq;

`ifdef SRAM_RD_RETRY_EN
    localparam int ERR_LAT = 9;
    localparam int ERR_WL  = 6;
    localparam bit ERR_RT  = 1'b1;
`else
    localparam int ERR_LAT = 5;
    localparam int ERR_WL  = 3;
    localparam bit ERR_RT  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_ready;
    logic [7:0] row_rd;
    logic       pre_en;
    real        bl  [8];
    real        blb [8];
    logic [7:0] rd_data;
    logic [7:0] rd_err;
    logic       rd_valid;
    logic       rd_retried;

    int checks = 0;
    int errors = 0;
    int lat;
    int ovl;
    int wl;
    bit rt;

    always #5 clk = ~clk;

    sram_read_seq #(
        .ROWS(8), .ADDR_W(4), .COLS(8), .PRE_CYC(1), .SETTLE_CYC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .row_rd   (row_rd),
        .pre_en   (pre_en),
        .bl_rd    (bl),
        .blb_rd   (blb),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
`ifdef SRAM_RD_RETRY_EN
        .rd_retried (rd_retried),
`endif
        .rd_valid (rd_valid)
    );

`ifndef SRAM_RD_RETRY_EN
    assign rd_retried = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input real b, input real bb);
        for (int c = 0; c < 8; c++) begin
            bl[c]  = b;
            blb[c] = bb;
        end
    endtask

    // Issue one request from IDLE (called at a negedge) and wait, bounded, for rd_valid
    task automatic run_read(input logic [3:0] a, input bit fix0);
        chk("ready_before_req", {31'd0, rd_ready}, 32'd1);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        lat = 1;
        ovl = 0;
        wl  = 0;
        while (!rd_valid && lat < 30) begin
            if (pre_en && (row_rd != 8'h00)) ovl++;
            if (row_rd != 8'h00) wl++;
            if (fix0 && lat == 5) begin
                bl[0]  = 1.5;
                blb[0] = 0.0;
            end
            @(negedge clk);
            lat++;
        end
        rt = rd_retried;
        chk("overlap_pre_wl", ovl, 0);
        @(negedge clk);
    endtask

    initial begin
        int acc_cnt;
        int val_cnt;
        int second_acc;
        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        set_all(1.5, 0.0);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", {31'd0, rd_ready}, 32'd1);
        chk("rst_row_rd", {24'd0, row_rd}, 32'd0);
        chk("rst_pre_en", {31'd0, pre_en}, 32'd0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", {24'd0, rd_data}, 32'd0);
        chk("rst_err", {24'd0, rd_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cycle-by-cycle sequence for row 3, all columns reading 1
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        @(negedge clk);
        rd_req = 1'b0;
        chk("c1_pre_en", {31'd0, pre_en}, 32'd1);
        chk("c1_row_rd", {24'd0, row_rd}, 32'd0);
        chk("c1_ready", {31'd0, rd_ready}, 32'd0);
        for (int cyc = 2; cyc <= 4; cyc++) begin
            @(negedge clk);
            chk($sformatf("c%0d_row_rd", cyc), {24'd0, row_rd}, 32'h08);
            chk($sformatf("c%0d_pre_en", cyc), {31'd0, pre_en}, 32'd0);
            chk($sformatf("c%0d_valid", cyc), {31'd0, rd_valid}, 32'd0);
        end
        @(negedge clk);
        chk("c5_valid", {31'd0, rd_valid}, 32'd1);
        chk("c5_row_rd", {24'd0, row_rd}, 32'd0);
        chk("c5_data", {24'd0, rd_data}, 32'hFF);
        chk("c5_err", {24'd0, rd_err}, 32'h00);
        @(negedge clk);
        chk("c6_valid_low", {31'd0, rd_valid}, 32'd0);
        chk("c6_data_hold", {24'd0, rd_data}, 32'hFF);

        // Alternating columns: odd read 1, even read 0
        for (int c = 0; c < 8; c++) begin
            bl[c]  = (c % 2 == 1) ? 1.5 : 0.0;
            blb[c] = (c % 2 == 1) ? 0.0 : 1.5;
        end
        run_read(4'd5, 1'b0);
        chk("alt_lat", lat, 5);
        chk("alt_data", {24'd0, rd_data}, 32'hAA);
        chk("alt_err", {24'd0, rd_err}, 32'h00);

        // Column 0 indeterminate; fixed before a second sense if retry exists
        set_all(1.5, 0.0);
        bl[0]  = 1.0;
        blb[0] = 1.0;
        run_read(4'd1, 1'b1);
        chk("indet_lat", lat, ERR_LAT);
`ifdef SRAM_RD_RETRY_EN
        chk("indet_data", {24'd0, rd_data}, 32'hFF);
        chk("indet_err", {24'd0, rd_err}, 32'h00);
`else
        chk("indet_data", {24'd0, rd_data}, 32'hFE);
        chk("indet_err", {24'd0, rd_err}, 32'h01);
`endif
        chk("indet_retried", {31'd0, rt}, {31'd0, ERR_RT});

        // Window edges: c0 2.2/-0.5 ->1, c1 2.21 ->err, c2 0.7/1.3 ->0, c3 1.3/0.7 ->1, c4 -0.5/2.2 ->0
        set_all(1.5, 0.0);
        bl[0] = 2.2;   blb[0] = -0.5;
        bl[1] = 2.21;  blb[1] = 0.0;
        bl[2] = 0.7;   blb[2] = 1.3;
        bl[3] = 1.3;   blb[3] = 0.7;
        bl[4] = -0.5;  blb[4] = 2.2;
        run_read(4'd0, 1'b0);
        chk("bnd_lat", lat, ERR_LAT);
        chk("bnd_data", {24'd0, rd_data}, 32'hE9);
        chk("bnd_err", {24'd0, rd_err}, 32'h02);
        chk("bnd_retried", {31'd0, rt}, {31'd0, ERR_RT});

        // rd_req held high: accepts only in IDLE, one valid per accept
        set_all(1.5, 0.0);
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        acc_cnt = 0;
        val_cnt = 0;
        second_acc = -1;
        ovl = 0;
        for (int i = 0; i < 12; i++) begin
            if (rd_req && rd_ready) begin
                acc_cnt++;
                if (acc_cnt == 2) second_acc = i;
            end
            if (rd_valid) val_cnt++;
            if (pre_en && (row_rd != 8'h00)) ovl++;
            @(negedge clk);
        end
        rd_req = 1'b0;
        chk("b2b_accepts", acc_cnt, 2);
        chk("b2b_second_accept", second_acc, 6);
        chk("b2b_valids", val_cnt, 2);
        chk("b2b_overlap", ovl, 0);
        repeat (8) @(negedge clk);
        chk("b2b_idle", {31'd0, rd_ready}, 32'd1);

        // Reset pulse during WL_ON aborts the read
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wl_before", {24'd0, row_rd}, 32'h08);
        #1 rst = 1'b1;
        #1;
        chk("abort_wl_async", {24'd0, row_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        val_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid) val_cnt++;
            @(negedge clk);
        end
        chk("abort_no_valid", val_cnt, 0);
        chk("abort_ready", {31'd0, rd_ready}, 32'd1);
        chk("abort_data_clr", {24'd0, rd_data}, 32'd0);

        // Out-of-range row: no wordline, all columns flagged
        set_all(1.5, 0.0);
        run_read(4'd9, 1'b0);
        chk("oor_lat", lat, ERR_LAT);
        chk("oor_wl_cycles", wl, 0);
        chk("oor_data", {24'd0, rd_data}, 32'h00);
        chk("oor_err", {24'd0, rd_err}, 32'hFF);

        // Wordline-on cycle count for a normal read
        run_read(4'd7, 1'b0);
        chk("wl_cycles", wl, 3);
        chk("wl_row7_data", {24'd0, rd_data}, 32'hFF);
        if (ERR_WL < 0) chk("unused", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
